age_select_scheduler: RTL

//  Picks the oldest ready requester (smallest unsigned age tag) out of N reservation-station slots.
//  It sequences one shared WIDTH-bit magnitude comparator across the slots, one slot per cycle.
//  It sits between the issue-queue wakeup logic and the issue port.
//  The result is held until the issue stage acknowledges it.

---
 rtl/age_select_scheduler.sv | 101 ++++++++++
 1 files changed

// File: rtl/age_select_scheduler.sv
// Oldest-ready selector: snapshots N slot requests/ages, then walks one shared
// magnitude comparator across the slots and holds the winner until acknowledged.
module age_select_scheduler #(
  parameter int N     = 8,
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N-1:0]       req_vec,
  input  logic [N*WIDTH-1:0] age_flat,
  output logic               busy,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [WIDTH-1:0]   grant_age,
  output logic               grant_none,
  input  logic               grant_ack
);

  // LOAD is the DONE-entry cycle that moves the running best into the grant registers.
  typedef enum logic [1:0] {IDLE, SCAN, LOAD, DONE} state_t;

  state_t             state, state_nx;
  logic [N-1:0]       snap_req;
  logic [WIDTH-1:0]   snap_age [N];
  logic [IDX_W-1:0]   ptr, best_idx;
  logic [WIDTH-1:0]   best_age, cur_age;
  logic               best_valid, win, last;

  always_comb begin
    cur_age = snap_age[ptr];
    win     = snap_req[ptr] && (!best_valid || (cur_age < best_age));
    last    = (ptr == IDX_W'(N - 1));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = SCAN;
      SCAN: if (last) state_nx = LOAD;
      LOAD: state_nx = DONE;
      DONE: if (grant_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_req    <= '0;
      for (int i = 0; i < N; i++) snap_age[i] <= '0;
      ptr         <= '0;
      best_valid  <= 1'b0;
      best_idx    <= '0;
      best_age    <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      grant_age   <= '0;
      grant_none  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          snap_req <= req_vec;
          for (int i = 0; i < N; i++) snap_age[i] <= age_flat[i*WIDTH +: WIDTH];
          ptr        <= '0;
          best_valid <= 1'b0;
          // Zeroed so an empty pass reports index 0 / age 0.
          best_idx   <= '0;
          best_age   <= '0;
        end
        SCAN: begin
          if (win) begin
            best_idx   <= ptr;
            best_age   <= cur_age;
            best_valid <= 1'b1;
          end
          if (!last) ptr <= ptr + IDX_W'(1);
        end
        LOAD: begin
          grant_valid <= 1'b1;
          grant_idx   <= best_idx;
          grant_age   <= best_age;
          grant_none  <= ~best_valid;
        end
        DONE: if (grant_ack) begin
          grant_valid <= 1'b0;
          grant_none  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
